// File: rtl/fp16_norm_arbiter.sv
// Round-robin front end that shares one two-cycle fp16 normalizer among NREQ requesters.
// A two-stage tag pipeline tracks each issued operand so results return with their requester id.
module fp16_norm_arbiter #(
  parameter int NREQ = 4,
  parameter int XW   = 26,
  parameter int NW   = 20,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ-1:0]      req_under,
  output logic [NREQ-1:0]      req_ready,
  output logic [XW-1:0]        norm_i,
  output logic                 norm_under_i,
  output logic                 norm_ce,
  input  logic [NW-1:0]        norm_o,
  input  logic                 norm_under_o,
  input  logic                 norm_inexact_o,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [NW-1:0]        res_o,
  output logic                 res_under,
  output logic                 res_inexact,
  input  logic                 res_ready,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          issue_cnt
);

  logic           s1_valid_q, s1_valid_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           s2_valid_q, s2_valid_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;
  logic [15:0]    issue_cnt_q, issue_cnt_d;

  logic [IDW-1:0] grant_id;
  logic           grant_hit;
  logic           issue;

  // Both operands stay below NREQ, so one conditional subtract implements mod NREQ.
  function automatic logic [IDW-1:0] ptr_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // The whole pipeline freezes only when a finished result is waiting on the consumer.
  assign norm_ce = !(s2_valid_q && !res_ready);

  always_comb begin
    grant_id  = rr_ptr_q;
    grant_hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_hit && req_valid[ptr_add(rr_ptr_q, k)]) begin
        grant_hit = 1'b1;
        grant_id  = ptr_add(rr_ptr_q, k);
      end
    end
  end

  assign issue = grant_hit && norm_ce && !rst;

  always_comb begin
    req_ready    = '0;
    norm_i       = req_x[XW-1:0];
    norm_under_i = req_under[0];
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        req_ready[i] = issue;
        norm_i       = req_x[i*XW +: XW];
        norm_under_i = req_under[i];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s2_valid_d  = s2_valid_q;
    s2_id_d     = s2_id_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    if (norm_ce) begin
      s2_valid_d = s1_valid_q;
      s2_id_d    = s1_id_q;
      s1_valid_d = issue;
      s1_id_d    = grant_id;
    end else begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (issue) begin
      rr_ptr_d    = ptr_add(grant_id, 1);
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign res_valid   = s2_valid_q;
  assign res_id      = s2_id_q;
  assign res_o       = norm_o;
  assign res_under   = norm_under_o;
  assign res_inexact = norm_inexact_o;
  assign stall_cnt   = stall_cnt_q;
  assign issue_cnt   = issue_cnt_q;

endmodule
